// File: rtl/mcu_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mcu_spi_slave
// Brief    : Mode-0 SPI slave front end for the system control register block.
//            Oversamples CS/SCLK/MOSI in the clk domain, deserialises MOSI
//            bytes into a one-cycle strobe with a frame-start flag and shifts
//            the control block's response byte out on MISO during the
//            following byte.
// Options  : `define MCU_SPI_GLITCH_FILTER_EN adds a 3-sample majority filter
//            on synchronised SCLK (rejects 1-clk pulses, +1 clk latency).
// Revision : 1.0 - initial release
// ============================================================================
module mcu_spi_slave #(
    parameter int SYNC_STAGES = 2          // legal range 2..4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_out_strobe,
    output logic       data_out_start,
    output logic [7:0] data_out,
    input  logic [7:0] tx_data,
    output logic       frame_active
);

    // ------------------------------------------------------------------
    // Input synchronisers. Chains reset to 0 so that, after reset, CS only
    // looks idle once a real high level has travelled through the chain;
    // this is what keeps a reset released mid-frame from arming early.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    // Shift each asynchronous pin through its synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic sclk_f;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

`ifdef MCU_SPI_GLITCH_FILTER_EN
    // Two previous SCLK samples for the majority vote
    logic [1:0] sclk_hist;

    // Keep a short history of synchronised SCLK
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_hist <= 2'b00;
        end else begin
            sclk_hist <= {sclk_hist[0], sclk_s};
        end
    end

    // 2-of-3 vote: a level must persist for two samples to be seen
    assign sclk_f = (sclk_s & sclk_hist[0]) |
                    (sclk_s & sclk_hist[1]) |
                    (sclk_hist[0] & sclk_hist[1]);
`else
    assign sclk_f = sclk_s;
`endif

    // ------------------------------------------------------------------
    // Edge detection. Events are registered so that CS and SCLK events
    // reach the core logic in the same aligned cycle; the CS branch is
    // evaluated first there, which gives it priority over a coincident
    // SCLK edge.
    // ------------------------------------------------------------------
    logic cs_prev;
    logic sclk_prev;
    logic cs_fall_e;
    logic cs_low_e;
    logic sclk_rise_e;
    logic sclk_fall_e;
    logic mosi_e;

    // Previous-value registers and registered edge events
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_prev     <= 1'b0;
            sclk_prev   <= 1'b0;
            cs_fall_e   <= 1'b0;
            cs_low_e    <= 1'b0;
            sclk_rise_e <= 1'b0;
            sclk_fall_e <= 1'b0;
            mosi_e      <= 1'b0;
        end else begin
            cs_prev     <= cs_s;
            sclk_prev   <= sclk_f;
            cs_fall_e   <= cs_prev & ~cs_s;
            cs_low_e    <= ~cs_s;
            sclk_rise_e <= sclk_f & ~sclk_prev;
            sclk_fall_e <= ~sclk_f & sclk_prev;
            mosi_e      <= mosi_s;
        end
    end

    // ------------------------------------------------------------------
    // Core shift/count logic
    // ------------------------------------------------------------------
    logic       armed;
    logic       start_pending;
    logic       byte_done;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;

    // MISO is the MSB of the transmit shifter: loading drives tx_data[7],
    // shifting presents the next bit, clearing drives 0.
    assign spi_miso = tx_shift[7];

    // Arming, bit counting, rx/tx shifting and the output strobe stage
    always_ff @(posedge clk) begin
        if (reset) begin
            armed           <= 1'b0;
            start_pending   <= 1'b0;
            byte_done       <= 1'b0;
            bit_cnt         <= 3'd0;
            rx_shift        <= 8'h00;
            tx_shift        <= 8'h00;
            data_out        <= 8'h00;
            data_out_strobe <= 1'b0;
            data_out_start  <= 1'b0;
            frame_active    <= 1'b0;
        end else begin
            // Output stage: one cycle after the eighth bit is captured
            byte_done       <= 1'b0;
            data_out_strobe <= byte_done;
            data_out_start  <= byte_done & start_pending;
            if (byte_done) begin
                data_out      <= rx_shift;
                start_pending <= 1'b0;
            end

            // Idle CS must be observed before any SCLK activity counts
            if (cs_s) begin
                armed <= 1'b1;
            end
            frame_active <= armed & ~cs_s;

            if (!armed) begin
                bit_cnt  <= 3'd0;
                tx_shift <= 8'h00;
            end else if (cs_fall_e) begin
                // New frame: first response byte is all zeros
                bit_cnt       <= 3'd0;
                start_pending <= 1'b1;
                tx_shift      <= 8'h00;
            end else if (!cs_low_e) begin
                // CS idle or just released: drop any partial byte
                bit_cnt       <= 3'd0;
                start_pending <= 1'b0;
                tx_shift      <= 8'h00;
            end else if (sclk_rise_e) begin
                rx_shift <= {rx_shift[6:0], mosi_e};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                end
            end else if (sclk_fall_e) begin
                // Counter at 0 marks the byte boundary, which trails the
                // strobe so a response registered after it goes out next
                if (bit_cnt == 3'd0) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI slave front end between the MCU SPI pins and the system control register block.
- Oversamples SCLK, CS and MOSI in the clk domain and deserialises MOSI bytes into a one-cycle strobe with a frame-start flag.
- Serialises the control block's response byte back out on MISO during the following byte.
- Sits directly upstream of the control block: its strobe/start/data outputs drive that block's data inputs, and that block's data_out drives tx_data.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of spi_cs_n, spi_sclk and spi_mosi. Legal range 2..4.

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency
- reset  input  1  synchronous, active-high
- spi_cs_n  input  1  MCU chip select, active low, asynchronous to clk
- spi_sclk  input  1  MCU SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
- spi_mosi  input  1  MCU data out, MSB first
- spi_miso  output  1  data to MCU, MSB first
- data_out_strobe  output  1  one-clk pulse: a complete byte was received
- data_out_start  output  1  byte is the first of a frame; valid with the strobe
- data_out  output  8  received byte; valid with the strobe, held until the next strobe
- tx_data  input  8  response byte from the control block; sampled at the byte boundary
- frame_active  output  1  synchronised, inverted CS; 1 while a frame is open

Behaviour:
- Reset values: data_out_strobe=0, data_out_start=0, data_out=8'h00, spi_miso=0, frame_active=0, bit counter=0, rx/tx shift registers=0, armed=0.
- Arming after reset:
  - armed sets only after synchronised CS has been seen high (idle) for at least one clk.
  - While unarmed, all SCLK edges are ignored, so a reset released mid-frame emits no bytes.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - One additional register per signal supplies the previous value for edge detection.
  - sclk_rise = current 1, previous 0; sclk_fall = current 0, previous 1.
- CS falling edge (synchronised):
  - Bit counter cleared to 0, start_pending set to 1.
  - tx shift register cleared, so spi_miso=0 for the first byte.
- While CS is high:
  - SCLK edges are ignored and the bit counter is held at 0.
  - spi_miso=0.
- sclk_rise with CS low and armed:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit counter increments (3-bit, wraps 7->0).
  - If the counter was 7, the next clk cycle drives:
    - data_out = the assembled byte;
    - data_out_strobe = 1;
    - data_out_start = start_pending.
  - start_pending clears on that strobe.
  - data_out_start is 0 whenever data_out_strobe is 0.
- Latency: the strobe asserts exactly SYNC_STAGES+2 clk cycles after the clk edge at which raw spi_sclk is first sampled high for bit 0.
- sclk_fall with CS low and armed:
  - If the bit counter is 0 (byte boundary, including before the first byte): tx_shift <= tx_data, spi_miso = tx_data[7].
  - Otherwise: tx_shift shifts left and spi_miso = next bit.
  - The byte boundary falls after the strobe, so a control-block response registered in the cycle after the strobe is transmitted during the next byte.
  - At the frame's first boundary, tx_data is loaded only on the first SCLK falling edge. No falling edge occurs before the first byte in mode 0, so the first byte returns 0s.
- CS rising edge mid-byte:
  - Partial byte discarded; no strobe.
  - Bit counter reset to 0, start_pending cleared, spi_miso=0.
- CS falls and SCLK rises in the same clk: the CS edge takes priority; that SCLK edge is ignored.
- Reset asserted mid-frame: all state returns to reset values; armed cleared.
- Back-to-back frames are legal provided CS is high for at least SYNC_STAGES+2 clk cycles between them.

Optional Feature:
- Macro: MCU_SPI_GLITCH_FILTER_EN.
- Defined:
  - Synchronised SCLK passes through a 3-sample majority filter before edge detection.
  - Pulses of 1 clk width are rejected.
  - Strobe latency becomes SYNC_STAGES+3.
- Undefined:
  - No filter; latency SYNC_STAGES+2.
  - A single-cycle SCLK glitch produces an extra bit.

Test Plan:
- Reset, CS low, send 8'h00 (status command) then one byte at SCLK = clk/8 -> strobes with data_out=8'h00 start=1, then start=0. With tx_data=8'h5C driven by the bench model after the first strobe, MISO returns 8'h5C on byte 2.
- Frame of 8'h02, 8'hA5, 8'h3C, 8'hFF -> four strobes with data 02/A5/3C/FF, start only on the first, and each strobe SYNC_STAGES+2 clks after bit 0's rising edge.
- CS rises after 5 bits of 8'h81, then a new frame sends 8'h04 -> no strobe for the partial byte; the next strobe carries 8'h04 with start=1.
- Reset asserted mid-byte while CS is low, released, SCLK keeps toggling -> no strobe until CS goes high then low. The first strobe of the new frame has start=1.
- tx_data changes to 8'h42 between strobe and boundary; the MCU samples MISO on rising edges -> reads 8'h42 MSB first. MISO=0 while CS is high.
- With MCU_SPI_GLITCH_FILTER_EN, inject a 1-clk SCLK high glitch mid-byte sending 8'h5A -> received 8'h5A. Without the macro, the received byte is corrupted.
